// File: rtl/id_scoreboard_pkg.sv
// Shared register-file and scoreboard constants for the ID stage.
// Index width, register count and pending-counter sizing live here so every consumer agrees.
package id_scoreboard_pkg;

    localparam int REG_INDEX_BUS = 5;
    localparam int REG_NUM       = 32;
    localparam int SB_CNT_W      = 2;
    localparam int SB_CNT_MAX    = (1 << SB_CNT_W) - 1;

    typedef logic [REG_INDEX_BUS-1:0] reg_idx_t;
    typedef logic [SB_CNT_W-1:0]      sb_cnt_t;
    typedef logic [REG_NUM-1:0]       reg_vec_t;

    // One-hot decode of a register index; x0 never produces a hit.
    function automatic reg_vec_t idx_onehot(input logic vld, input reg_idx_t idx);
        reg_vec_t v;
        v = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            v[i] = vld && (idx == REG_INDEX_BUS'(i));
        end
        return v;
    endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// ID-stage <-> scoreboard handshake bundle: issue request, writeback/kill releases, hazard status.
// The master modport is the ID/pipeline side; the slave modport is the scoreboard.
interface id_scoreboard_if;
    import id_scoreboard_pkg::*;

    logic     id_sb_issue_valid_i;
    logic     id_sb_ready_i;
    logic     id_sb_rs1_en_i;
    reg_idx_t id_sb_rs1_index_i;
    logic     id_sb_rs2_en_i;
    reg_idx_t id_sb_rs2_index_i;
    logic     id_sb_rd_en_i;
    reg_idx_t id_sb_rd_index_i;
    logic     id_sb_wb_valid_i;
    reg_idx_t id_sb_wb_index_i;
    logic     id_sb_kill_valid_i;
    reg_idx_t id_sb_kill_index_i;
    logic     id_sb_stall_o;
    logic     id_sb_issue_o;
    reg_vec_t id_sb_busy_o;
    logic     id_sb_err_o;

    modport master (
        output id_sb_issue_valid_i, id_sb_ready_i,
        output id_sb_rs1_en_i, id_sb_rs1_index_i, id_sb_rs2_en_i, id_sb_rs2_index_i,
        output id_sb_rd_en_i, id_sb_rd_index_i,
        output id_sb_wb_valid_i, id_sb_wb_index_i, id_sb_kill_valid_i, id_sb_kill_index_i,
        input  id_sb_stall_o, id_sb_issue_o, id_sb_busy_o, id_sb_err_o
    );

    modport slave (
        input  id_sb_issue_valid_i, id_sb_ready_i,
        input  id_sb_rs1_en_i, id_sb_rs1_index_i, id_sb_rs2_en_i, id_sb_rs2_index_i,
        input  id_sb_rd_en_i, id_sb_rd_index_i,
        input  id_sb_wb_valid_i, id_sb_wb_index_i, id_sb_kill_valid_i, id_sb_kill_index_i,
        output id_sb_stall_o, id_sb_issue_o, id_sb_busy_o, id_sb_err_o
    );

endinterface

// File: rtl/id_scoreboard_cnt_cell.sv
// Pending-write counter for one architectural register: +1 on issue, -1 per writeback/kill release.
// Latency: count updates at the next edge; eff/underflow are combinational. No backpressure of its own.
module sb_cnt_cell
    import id_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_wb_i,
    input  logic dec_kill_i,
    output logic eff_nz_o,
    output logic busy_o,
    output logic sat_o,
    output logic underflow_o
);

    sb_cnt_t             cnt_q, cnt_d;
    logic [SB_CNT_W:0]   avail;
    logic [SB_CNT_W:0]   rel;
    logic [SB_CNT_W:0]   diff;

    always_comb begin
        avail       = {1'b0, cnt_q} + {{SB_CNT_W{1'b0}}, inc_i};
        rel         = {{SB_CNT_W{1'b0}}, dec_wb_i} + {{SB_CNT_W{1'b0}}, dec_kill_i};
        diff        = avail - rel;
        underflow_o = rel > avail;
        // Excess releases are dropped: the count bottoms out at zero and the top flags the error.
        cnt_d       = underflow_o ? '0 : diff[SB_CNT_W-1:0];
        // Same-cycle releases are visible to readers, matching regfile write-through.
        eff_nz_o    = {1'b0, cnt_q} > rel;
        busy_o      = cnt_q != '0;
        sat_o       = cnt_q == sb_cnt_t'(SB_CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard for ID issue; optional stall-cycle counter under SCOREBOARD_PERF_EN.
// Latency: stall/issue combinational, busy/err one cycle after the event. Stall ignores EX ready.
module id_scoreboard
    import id_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    id_scoreboard_if.slave       sb_if
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [63:0]          id_sb_stall_cnt_o
`endif
);

    reg_vec_t inc_vec;
    reg_vec_t wb_vec;
    reg_vec_t kill_vec;
    reg_vec_t eff_nz;
    reg_vec_t busy;
    reg_vec_t sat;
    reg_vec_t uf;

    logic rs1_haz, rs2_haz, rd_haz;
    logic stall, issue;
    logic err_q, err_d;

    assign eff_nz[0] = 1'b0;
    assign busy[0]   = 1'b0;
    assign sat[0]    = 1'b0;
    assign uf[0]     = 1'b0;

    for (genvar g = 1; g < REG_NUM; g++) begin : g_cell
        sb_cnt_cell u_cell (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc_vec[g]),
            .dec_wb_i    (wb_vec[g]),
            .dec_kill_i  (kill_vec[g]),
            .eff_nz_o    (eff_nz[g]),
            .busy_o      (busy[g]),
            .sat_o       (sat[g]),
            .underflow_o (uf[g])
        );
    end

    always_comb begin
        wb_vec   = idx_onehot(sb_if.id_sb_wb_valid_i,   sb_if.id_sb_wb_index_i);
        kill_vec = idx_onehot(sb_if.id_sb_kill_valid_i, sb_if.id_sb_kill_index_i);

        rs1_haz = sb_if.id_sb_rs1_en_i && (sb_if.id_sb_rs1_index_i != '0)
                  && eff_nz[sb_if.id_sb_rs1_index_i];
        rs2_haz = sb_if.id_sb_rs2_en_i && (sb_if.id_sb_rs2_index_i != '0)
                  && eff_nz[sb_if.id_sb_rs2_index_i];
        // A saturated destination blocks even if a release lands this cycle.
        rd_haz  = sb_if.id_sb_rd_en_i && (sb_if.id_sb_rd_index_i != '0)
                  && sat[sb_if.id_sb_rd_index_i];

        stall   = sb_if.id_sb_issue_valid_i && (rs1_haz || rs2_haz || rd_haz);
        issue   = sb_if.id_sb_issue_valid_i && sb_if.id_sb_ready_i && !stall;
        inc_vec = idx_onehot(issue && sb_if.id_sb_rd_en_i, sb_if.id_sb_rd_index_i);

        err_d   = err_q || (|uf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sb_if.id_sb_stall_o = stall;
    assign sb_if.id_sb_issue_o = issue;
    assign sb_if.id_sb_busy_o  = busy;
    assign sb_if.id_sb_err_o   = err_q;

`ifdef SCOREBOARD_PERF_EN
    logic [63:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {63'd0, stall};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_sb_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed vector bench for id_scoreboard; checks stall/issue mid-cycle and busy/err after each edge.
module tb_id_scoreboard;
    import id_scoreboard_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    id_scoreboard_if sb_if ();

`ifdef SCOREBOARD_PERF_EN
    logic [63:0] stall_cnt;
`endif

    id_scoreboard dut (
        .clk   (clk),
        .rst   (rst),
        .sb_if (sb_if.slave)
`ifdef SCOREBOARD_PERF_EN
        ,
        .id_sb_stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v, rdy;
        logic       r1e; logic [4:0] r1;
        logic       r2e; logic [4:0] r2;
        logic       rde; logic [4:0] rd;
        logic       wbv; logic [4:0] wbi;
        logic       kv;  logic [4:0] ki;
        logic       st, is;
        logic [31:0] busy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, rdy, r1e, input logic [4:0] r1,
                                input logic r2e, input logic [4:0] r2,
                                input logic rde, input logic [4:0] rd,
                                input logic wbv, input logic [4:0] wbi,
                                input logic kv, input logic [4:0] ki,
                                input logic st, is, input logic [31:0] busy, input logic err);
        vec_t x;
        x.v = v; x.rdy = rdy; x.r1e = r1e; x.r1 = r1; x.r2e = r2e; x.r2 = r2;
        x.rde = rde; x.rd = rd; x.wbv = wbv; x.wbi = wbi; x.kv = kv; x.ki = ki;
        x.st = st; x.is = is; x.busy = busy; x.err = err;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        sb_if.id_sb_issue_valid_i = x.v;
        sb_if.id_sb_ready_i       = x.rdy;
        sb_if.id_sb_rs1_en_i      = x.r1e;
        sb_if.id_sb_rs1_index_i   = x.r1;
        sb_if.id_sb_rs2_en_i      = x.r2e;
        sb_if.id_sb_rs2_index_i   = x.r2;
        sb_if.id_sb_rd_en_i       = x.rde;
        sb_if.id_sb_rd_index_i    = x.rd;
        sb_if.id_sb_wb_valid_i    = x.wbv;
        sb_if.id_sb_wb_index_i    = x.wbi;
        sb_if.id_sb_kill_valid_i  = x.kv;
        sb_if.id_sb_kill_index_i  = x.ki;
    endtask

    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        drive(x);
        #1;
        chk({tag, ".stall"}, 64'(sb_if.id_sb_stall_o), 64'(x.st));
        chk({tag, ".issue"}, 64'(sb_if.id_sb_issue_o), 64'(x.is));
        @(posedge clk);
        #1;
        chk({tag, ".busy"}, 64'(sb_if.id_sb_busy_o), 64'(x.busy));
        chk({tag, ".err"},  64'(sb_if.id_sb_err_o),  64'(x.err));
    endtask

    vec_t idle;

    initial begin
        checks   = 0;
        failures = 0;
        idle = mk(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 32'h0, 0);
        drive(idle);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.busy",  64'(sb_if.id_sb_busy_o),  64'd0);
        chk("reset.err",   64'(sb_if.id_sb_err_o),   64'd0);
        chk("reset.stall", 64'(sb_if.id_sb_stall_o), 64'd0);

        //            v rdy r1e r1 r2e r2 rde rd wbv wbi kv ki st is busy         err
        vecs.push_back(mk(1,1, 1,0,  0,0,  1,0,  0,0,  0,0,  0,1, 32'h0,     0)); // x0 only
        vecs.push_back(mk(1,1, 1,0,  0,0,  1,0,  0,0,  0,0,  0,1, 32'h0,     0));
        vecs.push_back(mk(1,0, 1,3,  0,0,  1,3,  0,0,  0,0,  0,0, 32'h0,     0)); // ready gating
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,5,  0,0,  0,0,  0,1, 32'h20,    0));
        vecs.push_back(mk(1,0, 1,5,  0,0,  0,0,  0,0,  0,0,  1,0, 32'h20,    0)); // stall without ready
        vecs.push_back(mk(1,1, 1,5,  0,0,  1,6,  0,0,  0,0,  1,0, 32'h20,    0)); // RAW
        vecs.push_back(mk(1,1, 1,5,  0,0,  1,6,  1,5,  0,0,  0,1, 32'h40,    0)); // wb bypass
        vecs.push_back(mk(1,1, 0,0,  1,6,  1,7,  0,0,  0,0,  1,0, 32'h40,    0)); // rs2 RAW
        vecs.push_back(mk(0,0, 0,0,  0,0,  0,0,  1,6,  0,0,  0,0, 32'h0,     0));
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,7,  0,0,  0,0,  0,1, 32'h80,    0));
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,7,  0,0,  0,0,  0,1, 32'h80,    0));
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,7,  0,0,  0,0,  0,1, 32'h80,    0)); // cnt7=3
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,7,  1,7,  0,0,  1,0, 32'h80,    0)); // saturated
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,7,  0,0,  0,0,  0,1, 32'h80,    0)); // cnt 2 -> 3
        vecs.push_back(mk(0,0, 0,0,  0,0,  0,0,  1,7,  1,7,  0,0, 32'h80,    0)); // 3 -> 1
        vecs.push_back(mk(0,0, 0,0,  0,0,  0,0,  1,7,  0,0,  0,0, 32'h0,     0));
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,9,  0,0,  0,0,  0,1, 32'h200,   0));
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,9,  1,9,  1,9,  0,1, 32'h0,     0)); // inc+wb+kill
        vecs.push_back(mk(1,1, 1,9,  0,0,  0,0,  0,0,  0,0,  0,1, 32'h0,     0));
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,10, 0,0,  0,0,  0,1, 32'h400,   0));
        vecs.push_back(mk(1,1, 1,10, 1,10, 0,0,  0,0,  1,10, 0,1, 32'h0,     0)); // kill bypass
        vecs.push_back(mk(0,0, 0,0,  0,0,  0,0,  1,12, 0,0,  0,0, 32'h0,     1)); // underflow
        vecs.push_back(mk(0,0, 0,0,  0,0,  0,0,  0,0,  0,0,  0,0, 32'h0,     1)); // sticky
        vecs.push_back(mk(1,1, 0,0,  0,0,  1,0,  1,0,  1,0,  0,1, 32'h0,     1)); // x0 releases

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

`ifdef SCOREBOARD_PERF_EN
        chk("perf.stall_cnt", stall_cnt, 64'd4);
`endif

        // Load cnt[5]=2, then reset asynchronously between edges.
        apply(mk(1,1, 0,0, 0,0, 1,5, 0,0, 0,0, 0,1, 32'h20, 1), "pre_rst0");
        apply(mk(1,1, 0,0, 0,0, 1,5, 0,0, 0,0, 0,1, 32'h20, 1), "pre_rst1");
        @(negedge clk);
        drive(mk(1,1, 1,5, 0,0, 0,0, 0,0, 0,0, 0,0, 32'h0, 0));
        #1;
        chk("pre_rst.stall", 64'(sb_if.id_sb_stall_o), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst.busy",  64'(sb_if.id_sb_busy_o),  64'd0);
        chk("async_rst.err",   64'(sb_if.id_sb_err_o),   64'd0);
        chk("async_rst.stall", 64'(sb_if.id_sb_stall_o), 64'd0);
`ifdef SCOREBOARD_PERF_EN
        chk("async_rst.perf",  stall_cnt, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(idle);
        apply(mk(1,1, 1,5, 0,0, 0,0, 0,0, 0,0, 0,1, 32'h0, 0), "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
Register-hazard scoreboard sitting beside the ID-stage register file in the pipelined core. Tracks in-flight writes per architectural register with a small pending counter, and stalls ID issue when a source operand or destination cannot be safely serviced. Counters are released by writeback or by squash of killed instructions. This is the block that sequences when the register file's read data is valid for issue.

Parameters:
REG_NUM, 32, number of architectural registers; x0 is never tracked
CNT_W, 2, pending-counter width per register; saturation value CNT_MAX = 2^CNT_W-1

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
id_sb_issue_valid_i  input  1  ID holds a valid instruction attempting issue
id_sb_ready_i  input  1  EX can accept an instruction this cycle
id_sb_rs1_en_i  input  1  instruction reads rs1
id_sb_rs1_index_i  input  5  rs1 index
id_sb_rs2_en_i  input  1  instruction reads rs2
id_sb_rs2_index_i  input  5  rs2 index
id_sb_rd_en_i  input  1  instruction writes rd
id_sb_rd_index_i  input  5  rd index
id_sb_wb_valid_i  input  1  writeback retiring a register write this cycle (same cycle as regfile write)
id_sb_wb_index_i  input  5  writeback rd index
id_sb_kill_valid_i  input  1  an in-flight rd-writing instruction was squashed
id_sb_kill_index_i  input  5  squashed instruction's rd index
id_sb_stall_o  output  1  ID must hold; combinational
id_sb_issue_o  output  1  issue accepted this cycle; combinational
id_sb_busy_o  output  REG_NUM  bit i = counter[i] != 0 (registered state)
id_sb_err_o  output  1  sticky: release of a zero counter

Behaviour:
- Reset (async, rst=1): all counters 0, id_sb_busy_o=0, id_sb_err_o=0, perf counter 0; stall/issue follow from zero state.
- Index 0: never counted; rs/rd/wb/kill with index 0 ignored; rs index 0 never hazards.
- Effective pending: eff[i] = cnt[i] - (wb_valid & wb_index==i) - (kill_valid & kill_index==i), floored at 0 (same-cycle release visible, matching regfile write-through).
- Source hazard: rsN_en & rsN_index!=0 & eff[rsN_index]!=0.
- Dest hazard: rd_en & rd_index!=0 & cnt[rd_index]==CNT_MAX (saturation; same-cycle release does NOT relieve it).
- id_sb_stall_o = issue_valid & (rs1 hazard | rs2 hazard | dest hazard). Independent of id_sb_ready_i.
- id_sb_issue_o = issue_valid & id_sb_ready_i & ~id_sb_stall_o.
- Counter update at posedge: cnt[i] += issue_o & rd_en & rd_index==i & i!=0; -= wb hit; -= kill hit. All three may hit the same register in one cycle; net applied in one step.
- Underflow (a release hitting a counter whose value plus same-cycle increment is 0): that decrement dropped, counter stays 0, id_sb_err_o set until reset.
- wb and kill same index, counter 1, no issue: err set, counter 0.
- Latency: issue/wb/kill take effect on busy_o one cycle later; stall reacts combinationally to wb/kill same cycle.
- No flush port: the pipeline reports each squashed rd writer via kill, one per cycle.

Optional Feature:
Macro SCOREBOARD_PERF_EN. Defined: extra output id_sb_stall_cnt_o [63:0], increments each cycle id_sb_stall_o=1, cleared on reset, wraps at 2^64. Undefined: port and counter absent; remaining behaviour identical.

Decomposition:
- Shared defines file: REG_INDEX_BUS, REG_NUM, SB_CNT_W, SB_CNT_MAX; scoreboard constants join existing register-file defines.
- One sub-module, sb_cnt_cell: single-register counter with inc/dec_wb/dec_kill inputs, eff/busy/sat/underflow outputs; instantiated via generate for indices 1..REG_NUM-1.

Test Plan:
- Reset mid-operation: cnt[5]=2, assert rst asynchronously between edges -> busy_o=0 and err_o=0 immediately, before next clk edge.
- RAW stall: issue rd=5 (ready=1) -> busy_o[5]=1; next cycle rs1=5 -> stall_o=1, issue_o=0; wb_index=5 same cycle -> stall_o=0, issue_o=1.
- Saturation: CNT_W=2, issue rd=7 three times -> cnt=3; fourth rd=7 -> stall_o=1 even with wb_index=7 that cycle; following cycle (cnt=2) -> issue_o=1.
- Simultaneous events: cnt[9]=1, issue rd=9 with wb=9 and kill=9 same cycle -> cnt[9]=0, err_o=0.
- x0 / ready gating: rd=0, rs1=0 repeated -> stall_o=0, busy_o=0; rs1=3 with cnt[3]=0 and ready=0 -> stall_o=0, issue_o=0, no counter change.
- Underflow / perf: wb_index=12 with cnt[12]=0 -> err_o=1 and stays 1; with SCOREBOARD_PERF_EN, 4 stall cycles -> stall_cnt_o=4.
